// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI command sequencer.
// Optional watchdog on the write-data phase is enabled with SPI_SEQ_WDOG_EN.
package spi_seq_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned WDOG_W = 24;

  localparam logic [ADDR_W-1:0] ADDR_STATUS = 4'd0;
  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 4'd1;
  localparam logic [ADDR_W-1:0] ADDR_GATE   = 4'd2;
  localparam logic [ADDR_W-1:0] ADDR_CNT_LO = 4'd3;
  localparam logic [ADDR_W-1:0] ADDR_CNT_HI = 4'd4;

  localparam logic [DATA_W-1:0] ACK_TOKEN  = 16'hA5A5;
  localparam logic [DATA_W-1:0] BAD_TOKEN  = 16'hDEAD;
  localparam logic [DATA_W-1:0] GATE_RESET = 16'd1000;

  typedef enum logic {
    IDLE  = 1'b0,
    WDATA = 1'b1
  } seq_state_e;

  typedef struct packed {
    logic              wr;
    logic [2:0]        rsvd;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        arg;
  } cmd_word_t;

  function automatic logic [DATA_W-1:0] status_word(input logic       running,
                                                    input logic       err,
                                                    input logic [3:0] version);
    return {running, err, 10'b0, version};
  endfunction

  function automatic logic is_reserved(input logic [ADDR_W-1:0] addr);
    return addr > ADDR_CNT_HI;
  endfunction

endpackage

// File: rtl/spi_frame_sync.sv
// ss_n synchroniser and frame-end detector; captures the rx word at frame end.
module spi_frame_sync
  import spi_seq_pkg::*;
(
  input  logic              sysClk,
  input  logic              rst_n,
  input  logic              ss_n,
  input  logic [DATA_W-1:0] spi_rx,
  output logic              frame_done,
  output logic [DATA_W-1:0] cmd_q
);

  // [0],[1] synchroniser flops, [2] previous synchronised level
  logic [2:0] ss_sync;
  logic       rise_c;

  // Two consecutive high samples after a low one: single-cycle glitches never qualify
  assign rise_c = ss_sync[1] & ss_sync[0] & ~ss_sync[2];

  always_ff @(posedge sysClk) begin
    if (!rst_n) begin
      ss_sync    <= 3'b111;
      frame_done <= 1'b0;
      cmd_q      <= '0;
    end else begin
      ss_sync    <= {ss_sync[1:0], ss_n};
      frame_done <= rise_c;
      if (rise_c) cmd_q <= spi_rx;
    end
  end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Frame-level command decoder and register file behind the SPI slave.
// Define SPI_SEQ_WDOG_EN to add a timeout on the write-data phase.
module spi_cmd_sequencer
  import spi_seq_pkg::*;
#(
  parameter logic [3:0]        VERSION     = 4'h1,
  parameter logic [WDOG_W-1:0] WDOG_CYCLES = 24'd1_000_000
) (
  input  logic              sysClk,
  input  logic              rst_n,
  input  logic              ss_n,
  input  logic [DATA_W-1:0] spi_rx,
  output logic [DATA_W-1:0] spi_tx,
  input  logic [CNT_W-1:0]  count_in,
  input  logic              acq_running,
  output logic              acq_start,
  output logic              acq_stop,
  output logic [DATA_W-1:0] gate_cycles,
  output logic              cmd_err
);

  logic              frame_done;
  logic [DATA_W-1:0] cmd_q;
  cmd_word_t         cmd;

  seq_state_e        state;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  shadow;
  logic              wr_pend;
  logic [DATA_W-1:0] wr_data;

  logic [DATA_W-1:0] rd_data_c;
  logic              rd_bad_c;
  logic              err_apply_c;
  logic              unused_arg;

  spi_frame_sync u_sync (
    .sysClk     (sysClk),
    .rst_n      (rst_n),
    .ss_n       (ss_n),
    .spi_rx     (spi_rx),
    .frame_done (frame_done),
    .cmd_q      (cmd_q)
  );

  assign cmd        = cmd_q;
  assign unused_arg = ^cmd.arg;

`ifdef SPI_SEQ_WDOG_EN
  logic [WDOG_W-1:0] wdog_q;
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_CYCLES;
`endif

  // Read response mux; CNT_LO returns the live count, which is snapshotted the same cycle
  always_comb begin
    rd_data_c = BAD_TOKEN;
    rd_bad_c  = 1'b0;
    case (cmd.addr)
      ADDR_STATUS: rd_data_c = status_word(acq_running, cmd_err, VERSION);
      ADDR_CTRL:   rd_data_c = '0;
      ADDR_GATE:   rd_data_c = gate_cycles;
      ADDR_CNT_LO: rd_data_c = count_in[DATA_W-1:0];
      ADDR_CNT_HI: rd_data_c = shadow[CNT_W-1:DATA_W];
      default:     rd_bad_c  = 1'b1;
    endcase
  end

  // Error flag as it stands once the pending write lands, so the STATUS response reflects it
  always_comb begin
    err_apply_c = cmd_err;
    if (addr_q == ADDR_CTRL && wr_data[2]) err_apply_c = 1'b0;
  end

  always_ff @(posedge sysClk) begin
    if (!rst_n) begin
      state       <= IDLE;
      addr_q      <= '0;
      shadow      <= '0;
      wr_pend     <= 1'b0;
      wr_data     <= '0;
      spi_tx      <= '0;
      gate_cycles <= GATE_RESET;
      acq_start   <= 1'b0;
      acq_stop    <= 1'b0;
      cmd_err     <= 1'b0;
`ifdef SPI_SEQ_WDOG_EN
      wdog_q      <= '0;
`endif
    end else begin
      acq_start <= 1'b0;
      acq_stop  <= 1'b0;
      wr_pend   <= 1'b0;

      if (wr_pend) begin
        cmd_err <= err_apply_c;
        spi_tx  <= status_word(acq_running, err_apply_c, VERSION);
        case (addr_q)
          ADDR_CTRL: begin
            if (wr_data[1])      acq_stop  <= 1'b1;
            else if (wr_data[0]) acq_start <= 1'b1;
          end
          ADDR_GATE: gate_cycles <= wr_data;
          default: ;
        endcase
      end

      case (state)
        IDLE: begin
          if (frame_done) begin
            if (cmd.rsvd != 3'b000) cmd_err <= 1'b1;
            if (cmd.wr) begin
              state  <= WDATA;
              addr_q <= cmd.addr;
              spi_tx <= ACK_TOKEN;
              if (is_reserved(cmd.addr)) cmd_err <= 1'b1;
`ifdef SPI_SEQ_WDOG_EN
              wdog_q <= '0;
`endif
            end else begin
              spi_tx <= rd_data_c;
              if (rd_bad_c) cmd_err <= 1'b1;
              if (cmd.addr == ADDR_CNT_LO) shadow <= count_in;
            end
          end
        end
        WDATA: begin
          if (frame_done) begin
            wr_pend <= 1'b1;
            wr_data <= cmd_q;
            state   <= IDLE;
`ifdef SPI_SEQ_WDOG_EN
          end else if (wdog_q == WDOG_CYCLES) begin
            state   <= IDLE;
            cmd_err <= 1'b1;
            spi_tx  <= BAD_TOKEN;
          end else begin
            wdog_q  <= wdog_q + WDOG_W'(1);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_cmd_sequencer.md
Name: spi_cmd_sequencer

Overview:
- Frame-level controller behind the 16-bit SPI slave. Decodes host command frames from the slave's rx word and runs a small register file: acquisition start/stop, gate time, and atomic photon-count readout.
- Preloads the slave's tx word with the response for the next frame.
- Sits between the SPI slave and the photon-counter core, in the sysClk domain.

Parameters:
- VERSION, 4'h1, value reported in STATUS[3:0].
- WDOG_CYCLES, 24'd1_000_000, watchdog timeout in sysClk cycles. Used only with the optional feature.

Ports:
- sysClk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- ss_n  in  1  raw SPI slave-select; synchronised internally by two flops.
- spi_rx  in  16  received word from the SPI slave.
- spi_tx  out  16  word the SPI slave shifts out in the next frame.
- count_in  in  32  live photon count from the counter core.
- acq_running  in  1  counter core is acquiring.
- acq_start  out  1  one-cycle start pulse.
- acq_stop  out  1  one-cycle stop pulse.
- gate_cycles  out  16  gate length to the counter core.
- cmd_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset state:
  - spi_tx=16'h0000, gate_cycles=16'd1000, acq_start=0, acq_stop=0, cmd_err=0.
  - Count shadow = 0. State = IDLE.
- Frame end:
  - Defined as a rising edge of synchronised ss_n (frame_done pulse, 3 cycles after the pin edge).
  - spi_rx is captured into cmd_q in the frame_done cycle.
- Host timing requirement: ss_n high for at least 6 sysClk cycles between frames. spi_tx is stable no later than 2 cycles after frame_done and is held until the next frame_done.
- Command word layout:
  - [15] = W (1 = write).
  - [14:12] must be 0; non-zero sets cmd_err.
  - [11:8] = addr.
  - [7:0] ignored.
- Register map:
  - 0 STATUS, RO: {acq_running, cmd_err, 10'b0, VERSION}.
  - 1 CTRL, WO:
    - bit0 pulses acq_start.
    - bit1 pulses acq_stop.
    - bit2 clears cmd_err.
    - bit0 and bit1 both set: acq_stop only.
  - 2 GATE, RW: gate_cycles.
  - 3 CNT_LO, RO: the read snapshots count_in into the 32-bit shadow and returns shadow[15:0].
  - 4 CNT_HI, RO: returns shadow[31:16] with no new snapshot.
  - 5–15: reserved. Read returns 16'hDEAD and sets cmd_err. A write header to a reserved addr sets cmd_err and the following data frame is still consumed.
- State machine:
  - IDLE, on frame_done:
    - Read (W=0): load spi_tx with the register value. The response appears in the next frame. Stay in IDLE.
    - Write (W=1): go to WDATA and load spi_tx = 16'hA5A5 (ack token).
  - WDATA, on frame_done:
    - The captured word is write data. Apply it to addr_q in the following cycle. Pulses are exactly 1 cycle.
    - Load spi_tx = STATUS. Return to IDLE.
- Read of GATE after a write returns the new value.
- The snapshot is taken in the same cycle cmd_q is decoded, so a CNT_LO/CNT_HI pair is coherent.
- A count_in change between the CNT_LO and CNT_HI frames does not alter the shadow.
- Reset asserted mid-protocol (including in WDATA) returns to IDLE with all reset values. A pending write is discarded.
- ss_n glitch shorter than 2 cycles: filtered by the synchroniser. No frame_done is generated.

Optional Feature:
- Macro: SPI_SEQ_WDOG_EN.
- Defined:
  - A 24-bit counter runs while in WDATA and is cleared on entry.
  - Reaching WDOG_CYCLES returns the FSM to IDLE, sets cmd_err and loads spi_tx = 16'hDEAD. The pending write is dropped.
- Undefined: the counter is absent and WDATA waits indefinitely. WDOG_CYCLES is unused.

Decomposition:
- Shared package spi_seq_pkg contains:
  - Register address localparams (ADDR_STATUS … ADDR_CNT_HI).
  - Tokens ACK_TOKEN=16'hA5A5 and BAD_TOKEN=16'hDEAD.
  - FSM state encoding {IDLE, WDATA}.
  - GATE_RESET=16'd1000.
- One natural sub-module: spi_frame_sync. It contains the ss_n two-flop synchroniser, rising-edge detect producing frame_done, and the rx capture register.

Test Plan:
- Reset, then read STATUS (frame 0x0000, then frame 0x0000), with acq_running=0 and VERSION=1 → second frame's tx = 16'h0001; cmd_err=0, gate_cycles=1000.
- Write GATE: 16'h8200, then 16'h1234 → tx during the data frame = A5A5; gate_cycles=16'h1234 one cycle after the second frame_done. A subsequent read of 0x0200 returns 1234.
- CTRL write of data 16'h0003 → acq_stop pulses exactly 1 cycle; acq_start never asserts.
- count_in=32'h00AB_CDEF; read 0x0300, change count_in to 32'h1111_2222, read 0x0400 → responses CDEF, then 00AB.
- Read addr 7 (16'h0700) → response DEAD, cmd_err=1. STATUS[14]=1 until CTRL write 16'h0004 clears it.
- Send 16'h8200 and assert rst_n=0 for 1 cycle before the data frame; then send 16'h5555 → no write occurs; gate_cycles=1000 and the FSM is in IDLE. With SPI_SEQ_WDOG_EN and WDOG_CYCLES=100, send 16'h8200 and wait 100 cycles → FSM returns to IDLE, cmd_err=1, tx=DEAD.
